// File: rtl/dp_ctrl_pkg.sv
// Shared constants for the data-path arbiter: FSM encoding, slave address codes, word width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dp_ctrl_pkg;

    localparam int DATA_W_DFLT = 16;

    // Sequencer state encoding, kept as plain vectors for legacy tools.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // Address field codes carried in the top three bits of a requester word.
    localparam logic [2:0] ADDR_S0 = 3'b001;
    localparam logic [2:0] ADDR_S1 = 3'b010;
    localparam logic [2:0] ADDR_S2 = 3'b011;

endpackage

// File: rtl/dp_arbiter_if.sv
// Bundle of requester-side and slave-select signals of the shared data path.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until granted; no other flow control.
interface dp_arbiter_if
    import dp_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
);
    logic              req1;
    logic              req2;
    logic [DATA_W-1:0] data_in1;
    logic [DATA_W-1:0] data_in2;
    logic              gnt1;
    logic              gnt2;
    logic              sel1;
    logic              sel2;
    logic              mux1;
    logic              hsel_0;
    logic              hsel_1;
    logic              hsel_2;
    logic              busy;
    logic              done;
    logic              err;

    // Requester / environment side.
    modport master (
        output req1, req2, data_in1, data_in2,
        input  gnt1, gnt2, sel1, sel2, mux1,
        input  hsel_0, hsel_1, hsel_2, busy, done, err
    );

    // Arbiter side.
    modport slave (
        input  req1, req2, data_in1, data_in2,
        output gnt1, gnt2, sel1, sel2, mux1,
        output hsel_0, hsel_1, hsel_2, busy, done, err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a last-served pointer.
// Latency: pick is combinational; pointer moves on the edge where update is high.
// Backpressure: none; caller asserts update only when it commits to the pick.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic update,
    output logic win1,
    output logic win2
);

    // 1 means requester 2 was served last, so requester 1 wins the next tie.
    logic last2_q;
    logic last2_d;

    // Pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        win1 = req1 && (!req2 || last2_q);
        win2 = req2 && (!req1 || !last2_q);
    end

    // Pointer follows the committed winner.
    always_comb begin
        last2_d = last2_q;
        if (update) begin
            last2_d = win2;
        end
    end

    // Pointer register, reset so requester 1 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last2_q <= 1'b1;
        end else begin
            last2_q <= last2_d;
        end
    end

endmodule

// File: rtl/dp_arbiter.sv
// Grants the shared data path to one of two requesters, then runs GRANT/ADDR/DATA|ERR.
// Latency: request sampled at edge k -> hsel from k+2 for BEATS cycles, done one cycle after.
// Backpressure: requests are only sampled in IDLE; a started transfer always completes.
module dp_arbiter
    import dp_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int BEATS  = 4
) (
    input  logic         clk,
    input  logic         rst,
    dp_arbiter_if.slave  bus
);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       mux1_q,  mux1_d;
    logic [2:0] addr_q,  addr_d;
    logic [2:0] hsel_q,  hsel_d;
    logic       done_q,  done_d;

    logic win1;
    logic win2;
    logic arb_update;

    // Payload bits travel on the data path but are not looked at here.
    logic unused_payload;
    assign unused_payload = ^{bus.data_in1[DATA_W-4:0], bus.data_in2[DATA_W-4:0]};

    assign arb_update = (state_q == ST_IDLE) && (bus.req1 || bus.req2);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req1   (bus.req1),
        .req2   (bus.req2),
        .update (arb_update),
        .win1   (win1),
        .win2   (win2)
    );

    // Sequencer next state, beat counter, address capture and slave decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mux1_d  = mux1_q;
        addr_d  = addr_q;
        hsel_d  = 3'b000;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win1 || win2) begin
                    state_d = ST_GRANT;
                    mux1_d  = win2;
                end
            end
            ST_GRANT: begin
                // Winner's register is loaded this cycle; keep its address field.
                addr_d  = mux1_q ? bus.data_in2[DATA_W-1:DATA_W-3]
                                 : bus.data_in1[DATA_W-1:DATA_W-3];
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                cnt_d   = 4'(BEATS - 1);
                state_d = ST_DATA;
                case (addr_q)
                    ADDR_S0: hsel_d = 3'b001;
                    ADDR_S1: hsel_d = 3'b010;
                    ADDR_S2: hsel_d = 3'b100;
                    default: state_d = ST_ERR;
                endcase
            end
            ST_DATA: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    hsel_d = hsel_q;
                    cnt_d  = cnt_q - 4'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            mux1_q  <= 1'b0;
            addr_q  <= 3'b000;
            hsel_q  <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mux1_q  <= mux1_d;
            addr_q  <= addr_d;
            hsel_q  <= hsel_d;
            done_q  <= done_d;
        end
    end

    // Outputs decoded from registered state only.
    assign bus.gnt1   = (state_q == ST_GRANT) && !mux1_q;
    assign bus.gnt2   = (state_q == ST_GRANT) &&  mux1_q;
    assign bus.sel1   = bus.gnt1;
    assign bus.sel2   = bus.gnt2;
    assign bus.mux1   = mux1_q;
    assign bus.hsel_0 = hsel_q[0];
    assign bus.hsel_1 = hsel_q[1];
    assign bus.hsel_2 = hsel_q[2];
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_dp_arbiter.sv
// Drives two arbiter instances (BEATS=4 and BEATS=1) with directed and random traffic.
// Latency: outputs compared 1 time unit after every rising edge against a transaction model.
// Backpressure: n/a.
module tb_dp_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dp_arbiter_if #(.DATA_W(16)) if0 ();
    dp_arbiter_if #(.DATA_W(16)) if1 ();

    assign if1.req1     = if0.req1;
    assign if1.req2     = if0.req2;
    assign if1.data_in1 = if0.data_in1;
    assign if1.data_in2 = if0.data_in2;

    dp_arbiter #(.DATA_W(16), .BEATS(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    dp_arbiter #(.DATA_W(16), .BEATS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [10:0] act0, act1;
    assign act0 = {if0.gnt1, if0.gnt2, if0.sel1, if0.sel2, if0.mux1,
                   if0.hsel_0, if0.hsel_1, if0.hsel_2, if0.busy, if0.done, if0.err};
    assign act1 = {if1.gnt1, if1.gnt2, if1.sel1, if1.sel2, if1.mux1,
                   if1.hsel_0, if1.hsel_1, if1.hsel_2, if1.busy, if1.done, if1.err};

    // Transaction model: m_t = cycles since the grant started (-1 when idle).
    int   m_beats [2] = '{4, 1};
    int   m_t     [2] = '{-1, -1};
    int   m_slave [2] = '{0, 0};
    logic m_last2 [2] = '{1'b1, 1'b1};
    logic m_mux   [2] = '{1'b0, 1'b0};
    logic m_bad   [2] = '{1'b0, 1'b0};
    logic m_done  [2] = '{1'b0, 1'b0};
    int   grants  [2] = '{0, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic q1, input logic q2,
                              input logic [15:0] d1, input logic [15:0] d2);
        int field;
        m_done[i] = 1'b0;
        if (!r) begin
            m_t[i] = -1; m_last2[i] = 1'b1; m_mux[i] = 1'b0; m_bad[i] = 1'b0;
        end else if (m_t[i] < 0) begin
            if (q1 || q2) begin
                m_mux[i]   = (q1 && q2) ? !m_last2[i] : q2;
                m_last2[i] = m_mux[i];
                m_t[i]     = 0;
                grants[i]++;
            end
        end else if (m_t[i] == 0) begin
            field      = int'(m_mux[i] ? d2 : d1) / 8192;
            m_bad[i]   = (field < 1) || (field > 3);
            m_slave[i] = field - 1;
            m_t[i]     = 1;
        end else if (m_t[i] == 1) begin
            m_t[i] = 2;
        end else if (m_bad[i]) begin
            m_t[i] = -1;
        end else if (m_t[i] == m_beats[i] + 1) begin
            m_t[i] = -1; m_done[i] = 1'b1;
        end else begin
            m_t[i]++;
        end
    endtask

    function automatic logic [10:0] exp_vec(input int i);
        logic g, h;
        g = (m_t[i] == 0);
        h = (m_t[i] >= 2) && !m_bad[i];
        return {g && !m_mux[i], g && m_mux[i], g && !m_mux[i], g && m_mux[i], m_mux[i],
                h && (m_slave[i] == 0), h && (m_slave[i] == 1), h && (m_slave[i] == 2),
                m_t[i] >= 0, m_done[i], m_bad[i] && (m_t[i] == 2)};
    endfunction

    task automatic cyc(input logic r, input logic q1, input logic q2,
                       input logic [15:0] d1, input logic [15:0] d2);
        rst = r; if0.req1 = q1; if0.req2 = q2; if0.data_in1 = d1; if0.data_in2 = d2;
        @(posedge clk);
        model_step(0, r, q1, q2, d1, d2);
        model_step(1, r, q1, q2, d1, d2);
        #1;
        check_val("outs_b4", 32'(act0), 32'(exp_vec(0)));
        check_val("outs_b1", 32'(act1), 32'(exp_vec(1)));
        check_val("gnt_excl", 32'({if0.gnt1 & if0.gnt2, if1.gnt1 & if1.gnt2}), 32'd0);
        check_val("hsel_onehot", 32'({$countones({if0.hsel_0, if0.hsel_1, if0.hsel_2}) > 1,
                                      $countones({if1.hsel_0, if1.hsel_1, if1.hsel_2}) > 1}), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        logic [15:0] d1, d2;
        int g0;
        // Reset state.
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h2008, 16'h4008);
        check_val("reset_outs", 32'(act0), 32'd0);

        // Single transfer from requester 1 to slave 0.
        cyc(1'b1, 1'b1, 1'b0, 16'h2008, 16'h0000);
        idle(8);
        // Requester 2 to slave 1, then slave 2.
        cyc(1'b1, 1'b0, 1'b1, 16'h0000, 16'h4008);
        idle(7);
        cyc(1'b1, 1'b0, 1'b1, 16'h0000, 16'h6008);
        idle(7);
        // Tie held high: grants alternate.
        g0 = grants[0];
        for (int j = 0; j < 28; j++) cyc(1'b1, 1'b1, 1'b1, 16'h2008, 16'h4008);
        check_val("tie_grants_b4", 32'(grants[0] - g0), 32'd4);
        idle(8);
        // Bad address, then a tie.
        cyc(1'b1, 1'b1, 1'b0, 16'h8008, 16'h0000);
        idle(4);
        for (int j = 0; j < 14; j++) cyc(1'b1, 1'b1, 1'b1, 16'h2008, 16'h4008);
        idle(8);
        // Reset during the second beat of hsel_1.
        cyc(1'b1, 1'b0, 1'b1, 16'h0000, 16'h4008);
        idle(3);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_val("midreset_outs", 32'(act0), 32'd0);
        for (int j = 0; j < 14; j++) cyc(1'b1, 1'b1, 1'b1, 16'h2008, 16'h4008);
        idle(8);
        // Requester drops right after being granted.
        cyc(1'b1, 1'b1, 1'b0, 16'h6008, 16'h0000);
        idle(8);

        // Random traffic, mostly valid addresses, occasional reset.
        for (int j = 0; j < 3000; j++) begin
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            if ($urandom_range(0, 3) != 0) d1[15:13] = 3'($urandom_range(1, 3));
            if ($urandom_range(0, 3) != 0) d2[15:13] = 3'($urandom_range(1, 3));
            cyc($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), d1, d2);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
